fault_capture: RTL and testbench
================================

Name: fault_capture

Overview:
- Downstream consumer of the second pipeline stage. It checks each valid result word (finout qualified by DV_3) against a golden value computed on the clean path.
- It counts samples and mismatches, and buffers each mismatch as a 3-byte record in a small FIFO.
- It streams the buffered records to the UART transmitter over a valid/ready byte interface.
- It runs entirely in the glitched_clk domain, so it observes exactly what the glitched pipeline produced.

Parameters:
- DATA_W, 8, width of the result and golden words; also the UART byte width.
- FIFO_DEPTH, 4, number of fault records buffered; must be a power of two, at least 2.
- CNT_W, 16, width of the sample and fault counters.
- HDR, 8'hA5, header byte that starts every record.

Ports:
- glitched_clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous active-low reset
- finout  in  DATA_W  result word from the second stage
- DV_3  in  1  finout valid, one cycle per word
- exp_sum  in  DATA_W  golden result, aligned with finout/DV_3
- arm  in  1  1 = capture enabled; 0 = DV_3 ignored
- clr_stats  in  1  synchronous clear of the counters and ovf
- tx_data  out  DATA_W  byte to the UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts a byte
- sample_cnt  out  CNT_W  armed valid words seen, saturating
- fault_cnt  out  CNT_W  mismatches seen, saturating
- ovf  out  1  sticky: at least one fault record dropped because the FIFO was full
- busy  out  1  FIFO not empty or serializer not IDLE

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-transmission):
  - tx_valid=0, tx_data=0, sample_cnt=0, fault_cnt=0, ovf=0, busy=0.
  - FIFO emptied; serializer forced to IDLE.
  - On release, operation starts at the first rising edge with rst=1.
- Sample qualification: a "sample" is a rising edge with DV_3=1 and arm=1. It is a "fault" if finout != exp_sum. The compare is combinational on the inputs sampled at that edge.
- Counters:
  - Each sample increments sample_cnt; each fault increments fault_cnt.
  - Both hold at 2^CNT_W-1 (no wrap).
  - clr_stats=1 zeroes both counters and ovf at that edge; clr_stats wins over a simultaneous increment.
  - clr_stats does not flush the FIFO or the serializer.
- FIFO:
  - A fault writes record {obs=finout, exp=exp_sum} at the same edge.
  - Occupancy is judged before the edge. When full, the write is accepted only if the serializer pops at that same edge; otherwise the record is dropped and ovf is set.
  - A dropped record still counts in fault_cnt.
  - Pointers wrap modulo FIFO_DEPTH; the full/empty distinction uses an extra pointer bit.
- Serializer FSM, states IDLE, HDR, OBS, EXP:
  - IDLE: tx_valid=0. If the FIFO is non-empty, pop the head into a holding register and go to HDR.
  - HDR: tx_valid=1, tx_data=HDR.
  - OBS: tx_valid=1, tx_data=obs.
  - EXP: tx_valid=1, tx_data=exp.
  - Transitions: HDR->OBS->EXP occur only on an edge with tx_valid & tx_ready. From EXP, the handshake goes to HDR with a fresh pop if the FIFO is non-empty, else to IDLE. Back-to-back records therefore have no idle cycle.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable; tx_valid never drops before its handshake.
  - Outputs are registered.
- Latency: a fault at edge k gives tx_valid=1 with tx_data=HDR after edge k+1, provided the serializer was IDLE.
- arm=0: DV_3 has no effect on counters or FIFO. Records already queued continue to drain.
- busy is registered: (FIFO non-empty) | (state != IDLE).

Test Plan:
- Reset, arm=1, 10 samples with finout==exp_sum (0x00..0x09): sample_cnt=10, fault_cnt=0, tx_valid stays 0, busy=0.
- One fault (finout=0x3C, exp_sum=0x3D) at edge k, tx_ready=1: bytes A5, 3C, 3D on consecutive edges k+2..k+4, tx_valid first high after edge k+1; fault_cnt=1, then busy=0.
- tx_ready=0 with 6 faults (obs=0x10+i, exp=0x20+i) on consecutive edges: first record in the holding register, 4 in the FIFO, 1 dropped; ovf=1, fault_cnt=6. Then tx_ready=1: exactly 5 records (15 bytes) emitted, obs 0x10..0x14, with no idle cycles between records.
- Stall: tx_ready toggles 1,0,0,1 during a record: tx_data stays constant while stalled and no byte is duplicated or skipped. Simultaneous pop and push on a full FIFO: push accepted, ovf unchanged.
- Saturation/clear: preload or run 2^16+3 samples: sample_cnt=0xFFFF. clr_stats pulsed on a sample edge: counters=0 and ovf=0 after that edge. arm=0 with DV_3=1 and a mismatch: no change.
- Async reset asserted mid-OBS byte: tx_valid=0 immediately (before the next edge), all counters 0. After release, a new fault produces a clean A5/obs/exp record.

Source files
------------

// File: rtl/fault_capture_if.sv
// Sample bus from the second pipeline stage plus the valid/ready byte link to the UART TX.
// The master side is the environment (pipeline and UART); the slave side is fault_capture.
interface fault_capture_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] finout;
    logic              DV_3;
    logic [DATA_W-1:0] exp_sum;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output finout, DV_3, exp_sum, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  finout, DV_3, exp_sum, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/fault_capture.sv
// Compares armed result words against golden values, counts samples/faults, queues mismatches and
// streams them as {HDR, obs, exp} bytes; HDR is presented one edge after the fault edge when idle, held under tx_ready=0.
module fault_capture #(
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter int                CNT_W      = 16,
    parameter logic [DATA_W-1:0] HDR        = 8'hA5
) (
    input  logic              glitched_clk,
    input  logic              rst,
    fault_capture_if.slave    bus,
    input  logic              arm,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  fault_cnt,
    output logic              ovf,
    output logic              busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_OBS, S_EXP} state_t;

    state_t              state_q, state_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   obs_q, exp_q;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                ovf_q;
    logic [CNT_W-1:0]    smp_q, flt_q;
    logic                fifo_empty, fifo_full;
    logic                sample, fault, hs, pop, push, drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign sample = bus.DV_3 & arm;
    assign fault  = sample & (bus.finout != bus.exp_sum);
    assign hs     = tx_valid_q & bus.tx_ready;

    // A full FIFO still takes the record when the serializer frees a slot at the same edge.
    assign push = fault & (~fifo_full | pop);
    assign drop = fault & fifo_full & ~pop;

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: if (hs) state_d = S_OBS;
            S_OBS: if (hs) state_d = S_EXP;
            S_EXP: begin
                if (hs) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_HDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs follow the next state so the byte and its valid are registered together.
        case (state_d)
            S_HDR: begin tx_valid_d = 1'b1; tx_data_d = HDR;   end
            S_OBS: begin tx_valid_d = 1'b1; tx_data_d = obs_q; end
            S_EXP: begin tx_valid_d = 1'b1; tx_data_d = exp_q; end
            default: begin tx_valid_d = 1'b0; tx_data_d = '0;  end
        endcase
        busy_d = (wr_ptr_d != rd_ptr_d) | (state_d != S_IDLE);
    end

    always_ff @(posedge glitched_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            obs_q      <= '0;
            exp_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            if (pop) begin
                {obs_q, exp_q} <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge glitched_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.finout, bus.exp_sum};
        end
    end

    always_ff @(posedge glitched_clk or negedge rst) begin
        if (!rst) begin
            smp_q <= '0;
            flt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_stats) begin
            smp_q <= '0;
            flt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (sample && (smp_q != {CNT_W{1'b1}})) smp_q <= smp_q + CNT_W'(1);
            if (fault && (flt_q != {CNT_W{1'b1}}))  flt_q <= flt_q + CNT_W'(1);
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign sample_cnt   = smp_q;
    assign fault_cnt    = flt_q;
    assign ovf          = ovf_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_fault_capture.sv
// Bench for fault_capture: queue-based reference model of record buffering and byte streaming,
// directed scenarios followed by a randomized run compared cycle by cycle.
module tb_fault_capture;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm   = 1'b0;
    logic          clr   = 1'b0;
    logic [CW-1:0] sample_cnt, fault_cnt;
    logic          ovf, busy;

    fault_capture_if #(.DATA_W(DW)) bus ();

    fault_capture #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW), .HDR(8'hA5)) dut (
        .glitched_clk (clk),
        .rst          (rst_n),
        .bus          (bus),
        .arm          (arm),
        .clr_stats    (clr),
        .sample_cnt   (sample_cnt),
        .fault_cnt    (fault_cnt),
        .ovf          (ovf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes of the record on the wire, queued records, statistics.
    logic [7:0]  m_cur[$];
    logic [15:0] m_fifo[$];
    int unsigned m_smp, m_flt;
    bit          m_ovf;

    task automatic model_reset();
        m_cur.delete();
        m_fifo.delete();
        m_smp = 0;
        m_flt = 0;
        m_ovf = 0;
    endtask

    task automatic model_edge();
        bit          hs, flt, drp;
        logic [15:0] r;
        hs  = (m_cur.size() != 0) && bus.tx_ready;
        drp = 0;
        if (hs) void'(m_cur.pop_front());
        if (m_cur.size() == 0 && m_fifo.size() != 0) begin
            r = m_fifo.pop_front();
            m_cur.push_back(8'hA5);
            m_cur.push_back(r[15:8]);
            m_cur.push_back(r[7:0]);
        end
        flt = bus.DV_3 && arm && (bus.finout != bus.exp_sum);
        if (flt) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back({bus.finout, bus.exp_sum});
            else drp = 1;
        end
        if (clr) begin
            m_smp = 0;
            m_flt = 0;
            m_ovf = 0;
        end else begin
            if (bus.DV_3 && arm && m_smp < 65535) m_smp++;
            if (flt && m_flt < 65535) m_flt++;
            if (drp) m_ovf = 1;
        end
    endtask

    task automatic cyc(input logic dv, input logic a, input logic [7:0] fo, input logic [7:0] ex,
                       input logic rdy, input logic c);
        @(negedge clk);
        bus.DV_3     = dv;
        arm          = a;
        bus.finout   = fo;
        bus.exp_sum  = ex;
        bus.tx_ready = rdy;
        clr          = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        bus.DV_3 = 0; bus.finout = 0; bus.exp_sum = 0; bus.tx_ready = 0;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx: valid=%b data=%h want 0/00", bus.tx_valid, bus.tx_data);
        end
        checks++;
        if (sample_cnt !== 16'd0 || fault_cnt !== 16'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_stats: smp=%h flt=%h ovf=%b busy=%b want all 0", sample_cnt, fault_cnt, ovf, busy);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_clean_samples();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 8'(i), 8'(i), 1, 0);
            checks++;
            if (bus.tx_valid !== 1'b0) begin
                errors++; $display("FAIL clean_valid[%0d]: got %b want 0", i, bus.tx_valid);
            end
        end
        checks++;
        if (sample_cnt !== 16'd10 || fault_cnt !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL clean_stats: smp=%0d flt=%0d busy=%b want 10/0/0", sample_cnt, fault_cnt, busy);
        end
    endtask

    task automatic test_single_fault();
        logic [7:0] ev [4];
        logic [7:0] ed [4];
        ev = '{8'd1, 8'd1, 8'd1, 8'd0};
        ed = '{8'hA5, 8'h3C, 8'h3D, 8'h00};
        cyc(1, 1, 8'h3C, 8'h3D, 1, 0);
        checks++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_k: valid=%b busy=%b want 0/1", bus.tx_valid, busy);
        end
        for (int j = 0; j < 4; j++) begin
            cyc(0, 1, 8'h00, 8'h00, 1, 0);
            checks++;
            if (bus.tx_valid !== ev[j][0] || (ev[j][0] && bus.tx_data !== ed[j])) begin
                errors++; $display("FAIL single_byte[%0d]: valid=%b data=%h want %b/%h", j, bus.tx_valid, bus.tx_data, ev[j][0], ed[j]);
            end
        end
        checks++;
        if (fault_cnt !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_end: flt=%0d busy=%b want 1/0", fault_cnt, busy);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got[$];
        int first, last;
        cyc(0, 1, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 1, 8'h10 + 8'(i), 8'h20 + 8'(i), 0, 0);
        checks++;
        if (ovf !== 1'b1 || fault_cnt !== 16'd6 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
            errors++; $display("FAIL ovf_fill: ovf=%b flt=%0d valid=%b data=%h want 1/6/1/a5", ovf, fault_cnt, bus.tx_valid, bus.tx_data);
        end
        first = -1; last = -1;
        for (int c = 0; c < 22; c++) begin
            if (bus.tx_valid === 1'b1) begin
                got.push_back(bus.tx_data);
                if (first < 0) first = c;
                last = c;
            end
            cyc(0, 1, 8'h00, 8'h00, 1, 0);
        end
        checks++;
        if (got.size() != 15 || (last - first + 1) != 15) begin
            errors++; $display("FAIL ovf_drain_count: bytes=%0d span=%0d want 15/15", got.size(), last - first + 1);
        end else begin
            for (int r = 0; r < 5; r++) begin
                checks++;
                if (got[3*r] !== 8'hA5 || got[3*r+1] !== 8'h10 + 8'(r) || got[3*r+2] !== 8'h20 + 8'(r)) begin
                    errors++; $display("FAIL ovf_rec[%0d]: got %h %h %h want a5 %h %h", r, got[3*r], got[3*r+1], got[3*r+2], 8'h10 + 8'(r), 8'h20 + 8'(r));
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_end: busy=%b ovf=%b want 0/1", busy, ovf);
        end
    endtask

    task automatic test_stall_fullpush();
        logic [7:0] got[$];
        logic       rp [10];
        bit         injected;
        int         nbytes;
        rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        cyc(1, 1, 8'h55, 8'hAA, 1, 0);
        cyc(0, 1, 8'h00, 8'h00, 1, 0);
        for (int c = 0; c < 10; c++) begin
            if (bus.tx_valid === 1'b1 && rp[c] === 1'b1) got.push_back(bus.tx_data);
            cyc(0, 1, 8'h00, 8'h00, rp[c], 0);
            checks++;
            if (bus.tx_valid !== (m_cur.size() != 0) || (m_cur.size() != 0 && bus.tx_data !== m_cur[0])) begin
                errors++; $display("FAIL stall_cyc[%0d]: valid=%b data=%h want %b/%h", c, bus.tx_valid, bus.tx_data, m_cur.size() != 0, (m_cur.size() != 0) ? m_cur[0] : 8'h00);
            end
        end
        checks++;
        if (got.size() != 3 || got[0] !== 8'hA5 || got[1] !== 8'h55 || got[2] !== 8'hAA) begin
            errors++; $display("FAIL stall_bytes: n=%0d want 3 bytes a5 55 aa", got.size());
        end
        // Fill holding register plus FIFO, then push exactly on the EXP handshake while full.
        cyc(0, 1, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 8'h60 + 8'(i), 8'h70 + 8'(i), 0, 0);
        injected = 0;
        nbytes = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.tx_valid === 1'b1) nbytes++;
            if (!injected && m_cur.size() == 1 && m_fifo.size() == DEPTH) begin
                injected = 1;
                cyc(1, 1, 8'h99, 8'h98, 1, 0);
            end else begin
                cyc(0, 1, 8'h00, 8'h00, 1, 0);
            end
        end
        checks++;
        if (!injected || ovf !== 1'b0 || fault_cnt !== 16'd6 || nbytes != 18) begin
            errors++; $display("FAIL full_push: inj=%0d ovf=%b flt=%0d bytes=%0d want 1/0/6/18", injected, ovf, fault_cnt, nbytes);
        end
    endtask

    task automatic test_random();
        logic       dv, a, rdy, c;
        logic [7:0] fo, ex;
        for (int n = 0; n < 400; n++) begin
            dv  = ($urandom_range(0, 99) < 60);
            a   = ($urandom_range(0, 99) < 85);
            rdy = ($urandom_range(0, 99) < 55);
            c   = ($urandom_range(0, 99) < 2);
            fo  = 8'($urandom);
            ex  = ($urandom_range(0, 1) == 0) ? fo : 8'($urandom);
            cyc(dv, a, fo, ex, rdy, c);
            checks++;
            if (bus.tx_valid !== (m_cur.size() != 0) || (m_cur.size() != 0 && bus.tx_data !== m_cur[0])
                || busy !== ((m_cur.size() != 0) || (m_fifo.size() != 0))) begin
                errors++; $display("FAIL rnd_tx[%0d]: valid=%b data=%h busy=%b want %b/%h/%b", n, bus.tx_valid, bus.tx_data, busy,
                                   m_cur.size() != 0, (m_cur.size() != 0) ? m_cur[0] : 8'h00, (m_cur.size() != 0) || (m_fifo.size() != 0));
            end
            checks++;
            if (sample_cnt !== CW'(m_smp) || fault_cnt !== CW'(m_flt) || ovf !== m_ovf) begin
                errors++; $display("FAIL rnd_stats[%0d]: smp=%0d flt=%0d ovf=%b want %0d/%0d/%b", n, sample_cnt, fault_cnt, ovf, m_smp, m_flt, m_ovf);
            end
        end
    endtask

    task automatic test_saturation_clear();
        logic [7:0] v;
        cyc(0, 1, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 1, 8'h40 + 8'(i), 8'h00, 0, 0);
        for (int i = 0; i < 65539; i++) begin
            v = 8'($urandom);
            cyc(1, 1, v, v, 1, 0);
        end
        checks++;
        if (sample_cnt !== 16'hFFFF || fault_cnt !== 16'd6 || ovf !== 1'b1) begin
            errors++; $display("FAIL sat: smp=%h flt=%0d ovf=%b want ffff/6/1", sample_cnt, fault_cnt, ovf);
        end
        cyc(1, 1, 8'h01, 8'h02, 1, 1);
        checks++;
        if (sample_cnt !== 16'd0 || fault_cnt !== 16'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL clr_on_sample: smp=%0d flt=%0d ovf=%b want 0/0/0", sample_cnt, fault_cnt, ovf);
        end
        repeat (8) cyc(0, 1, 8'h00, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h11, 8'h22, 1, 0);
        checks++;
        if (sample_cnt !== 16'd0 || fault_cnt !== 16'd0 || bus.tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL disarmed: smp=%0d flt=%0d valid=%b busy=%b want 0/0/0/0", sample_cnt, fault_cnt, bus.tx_valid, busy);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] ev [4];
        logic [7:0] ed [4];
        ev = '{8'd1, 8'd1, 8'd1, 8'd0};
        ed = '{8'hA5, 8'h42, 8'h24, 8'h00};
        cyc(1, 1, 8'h77, 8'h88, 1, 0);
        cyc(0, 1, 8'h00, 8'h00, 1, 0);
        cyc(0, 1, 8'h00, 8'h00, 1, 0);
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h77) begin
            errors++; $display("FAIL pre_reset_obs: valid=%b data=%h want 1/77", bus.tx_valid, bus.tx_data);
        end
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (bus.tx_valid !== 1'b0 || sample_cnt !== 16'd0 || fault_cnt !== 16'd0 || busy !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL async_reset: valid=%b smp=%0d flt=%0d busy=%b ovf=%b want all 0", bus.tx_valid, sample_cnt, fault_cnt, busy, ovf);
        end
        @(negedge clk);
        rst_n = 1;
        cyc(1, 1, 8'h42, 8'h24, 1, 0);
        for (int j = 0; j < 4; j++) begin
            cyc(0, 1, 8'h00, 8'h00, 1, 0);
            checks++;
            if (bus.tx_valid !== ev[j][0] || (ev[j][0] && bus.tx_data !== ed[j])) begin
                errors++; $display("FAIL post_reset_byte[%0d]: valid=%b data=%h want %b/%h", j, bus.tx_valid, bus.tx_data, ev[j][0], ed[j]);
            end
        end
        checks++;
        if (fault_cnt !== 16'd1 || sample_cnt !== 16'd1) begin
            errors++; $display("FAIL post_reset_stats: smp=%0d flt=%0d want 1/1", sample_cnt, fault_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_samples();
        test_single_fault();
        test_overflow();
        test_stall_fullpush();
        test_random();
        test_saturation_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
